xgriscv_halt_ctrl: RTL and testbench

Retirement monitor and halt controller for the pipelined xgriscv core. Observes the writeback-stage PC and retire-valid, counts cycles and retired instructions, and stops the core on a PC breakpoint, a retire-count limit, or a no-retire watchdog. It asserts `freeze` back into the pipeline and reports a sticky `halted` status with a reason code. Gives synthesized builds and the board the same "stop at PC" behaviour the simulation bench relies on.

---
 rtl/xgriscv_halt_ctrl.sv | 125 ++++++++++++
 tb/tb_xgriscv_halt_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_halt_ctrl.sv
// Retirement monitor and halt controller: counts cycles and retirements in the
// writeback stage and freezes the core on a PC breakpoint, retire limit or watchdog.
module xgriscv_halt_ctrl #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validW,
    input  logic [31:0]      pcW,
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
    input  logic [CNT_W-1:0] max_retire,
    input  logic             resume,
    output logic             freeze,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [31:0]      last_pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    // 17 bits covers the largest legal TIMEOUT-1 (65535) with headroom.
    localparam int unsigned   WdW    = 17;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    localparam logic [1:0] ReasonNone = 2'b00;
    localparam logic [1:0] ReasonBp   = 2'b01;
    localparam logic [1:0] ReasonLim  = 2'b10;
    localparam logic [1:0] ReasonWd   = 2'b11;

    typedef enum logic [1:0] {
        StRun,
        StHalted,
        StStep
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       reason_q, reason_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [WdW-1:0]   wd_q, wd_d;

    logic bp_hit, lim_hit, wd_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            reason_q  <= ReasonNone;
            last_pc_q <= '0;
            retire_q  <= '0;
            cycle_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            last_pc_q <= last_pc_d;
            retire_q  <= retire_d;
            cycle_q   <= cycle_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        // A step must be able to leave the breakpoint it stopped on.
        bp_hit  = validW && bp_en && (pcW == bp_pc)
                  && !((state_q == StStep) && (pcW == last_pc_q));
        // Widened by one bit so the limit still fires at a saturated count.
        lim_hit = validW && (max_retire != '0)
                  && (({1'b0, retire_q} + (CNT_W + 1)'(1)) >= {1'b0, max_retire});
        wd_hit  = !validW && (wd_q == WdLast);
    end

    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        last_pc_d = last_pc_q;
        retire_d  = retire_q;
        cycle_d   = cycle_q;
        wd_d      = wd_q;

        unique case (state_q)
            StRun, StStep: begin
                cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
                if (validW) begin
                    retire_d  = (retire_q == '1) ? retire_q : retire_q + CNT_W'(1);
                    last_pc_d = pcW;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end

                if (bp_hit) begin
                    state_d  = StHalted;
                    reason_d = ReasonBp;
                end else if (lim_hit) begin
                    state_d  = StHalted;
                    reason_d = ReasonLim;
                end else if (wd_hit) begin
                    state_d  = StHalted;
                    reason_d = ReasonWd;
                end else if ((state_q == StStep) && validW && (pcW != last_pc_q)) begin
                    state_d = StRun;
                end
            end
            StHalted: begin
                if (resume) begin
                    state_d  = StStep;
                    reason_d = ReasonNone;
                    wd_d     = '0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    assign freeze      = (state_q == StHalted);
    assign halted      = (state_q == StHalted);
    assign halt_reason = reason_q;
    assign last_pc     = last_pc_q;
    assign retire_cnt  = retire_q;
    assign cycle_cnt   = cycle_q;

endmodule

// File: tb/tb_xgriscv_halt_ctrl.sv
// Directed self-checking bench for xgriscv_halt_ctrl; a narrow-counter instance
// covers saturation and the all-ones retire limit.
module tb_xgriscv_halt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        validW;
    logic [31:0] pcW;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic [31:0] max_retire;
    logic [2:0]  max_retire_s;
    logic        resume;

    logic        freeze, halted;
    logic [1:0]  halt_reason;
    logic [31:0] last_pc, retire_cnt, cycle_cnt;

    logic        freeze_s, halted_s;
    logic [1:0]  halt_reason_s;
    logic [31:0] last_pc_s;
    logic [2:0]  retire_cnt_s, cycle_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xgriscv_halt_ctrl #(.TIMEOUT(8), .CNT_W(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .validW     (validW),
        .pcW        (pcW),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .max_retire (max_retire),
        .resume     (resume),
        .freeze     (freeze),
        .halted     (halted),
        .halt_reason(halt_reason),
        .last_pc    (last_pc),
        .retire_cnt (retire_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    xgriscv_halt_ctrl #(.TIMEOUT(1024), .CNT_W(3)) u_dut_sat (
        .clk        (clk),
        .rst        (rst),
        .validW     (validW),
        .pcW        (pcW),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .max_retire (max_retire_s),
        .resume     (resume),
        .freeze     (freeze_s),
        .halted     (halted_s),
        .halt_reason(halt_reason_s),
        .last_pc    (last_pc_s),
        .retire_cnt (retire_cnt_s),
        .cycle_cnt  (cycle_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input logic v, input logic [31:0] pc);
        validW = v;
        pcW    = pc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        validW = 1'b0;
        resume = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_freeze"}, 32'(freeze), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_reason"}, 32'(halt_reason), 32'd0);
        check({tag, "_last_pc"}, last_pc, 32'd0);
        check({tag, "_retire"}, retire_cnt, 32'd0);
        check({tag, "_cycle"}, cycle_cnt, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        validW       = 1'b0;
        pcW          = '0;
        bp_en        = 1'b0;
        bp_pc        = '0;
        max_retire   = '0;
        max_retire_s = '0;
        resume       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst");

        // Breakpoint at 0xC
        bp_en = 1'b1;
        bp_pc = 32'hC;
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h4);
        cyc(1'b1, 32'h8);
        check("bp_not_yet", 32'(halted), 32'd0);
        cyc(1'b1, 32'hC);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_freeze", 32'(freeze), 32'd1);
        check("bp_reason", 32'(halt_reason), 32'd1);
        check("bp_retire", retire_cnt, 32'd4);
        check("bp_last_pc", last_pc, 32'hC);
        check("bp_cycle", cycle_cnt, 32'd4);
        cyc(1'b1, 32'h100);
        check("bp_hold_retire", retire_cnt, 32'd4);
        check("bp_hold_last_pc", last_pc, 32'hC);

        // Step over the breakpoint
        resume = 1'b1;
        cyc(1'b0, 32'h0);
        resume = 1'b0;
        check("step_freeze", 32'(freeze), 32'd0);
        check("step_halted", 32'(halted), 32'd0);
        check("step_reason", 32'(halt_reason), 32'd0);
        cyc(1'b1, 32'hC);
        check("step_no_rehalt", 32'(halted), 32'd0);
        cyc(1'b1, 32'h10);
        check("step_exit_halted", 32'(halted), 32'd0);
        check("step_retire", retire_cnt, 32'd6);
        cyc(1'b1, 32'hC);
        check("step_rehalt", 32'(halted), 32'd1);
        check("step_rehalt_reason", 32'(halt_reason), 32'd1);
        check("step_rehalt_retire", retire_cnt, 32'd7);
        check("step_rehalt_cycle", cycle_cnt, 32'd7);

        // Reset while halted, then counting resumes
        do_reset();
        check_reset_outputs("rst_halted");
        cyc(1'b0, 32'h0);
        check("rst_resume_cycle", cycle_cnt, 32'd1);
        check("rst_resume_retire", retire_cnt, 32'd0);

        // Retire limit of 3
        do_reset();
        bp_en      = 1'b0;
        max_retire = 32'd3;
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h4);
        check("lim_not_yet", 32'(halted), 32'd0);
        cyc(1'b1, 32'h8);
        check("lim_halted", 32'(halted), 32'd1);
        check("lim_reason", 32'(halt_reason), 32'd2);
        check("lim_retire", retire_cnt, 32'd3);
        cyc(1'b1, 32'hC);
        cyc(1'b1, 32'h10);
        check("lim_hold_retire", retire_cnt, 32'd3);
        check("lim_hold_last_pc", last_pc, 32'h8);

        // BP and LIM on the same retirement
        do_reset();
        bp_en      = 1'b1;
        bp_pc      = 32'h8;
        max_retire = 32'd3;
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h4);
        cyc(1'b1, 32'h8);
        check("prio_halted", 32'(halted), 32'd1);
        check("prio_reason", 32'(halt_reason), 32'd1);

        // Watchdog, TIMEOUT = 8
        do_reset();
        bp_en      = 1'b0;
        max_retire = '0;
        cyc(1'b1, 32'h20);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0);
        check("wd_not_yet", 32'(halted), 32'd0);
        cyc(1'b0, 32'h0);
        check("wd_halted", 32'(halted), 32'd1);
        check("wd_reason", 32'(halt_reason), 32'd3);
        check("wd_cycle", cycle_cnt, 32'd9);
        check("wd_last_pc", last_pc, 32'h20);

        // A retire at idle cycle 7 restarts the watchdog
        do_reset();
        cyc(1'b1, 32'h20);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0);
        cyc(1'b1, 32'h24);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0);
        check("wd_kick_no_halt", 32'(halted), 32'd0);
        cyc(1'b0, 32'h0);
        check("wd_kick_halt", 32'(halted), 32'd1);

        // Watchdog expiry coincident with reset
        do_reset();
        cyc(1'b1, 32'h20);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0);
        rst = 1'b1;
        cyc(1'b0, 32'h0);
        rst = 1'b0;
        check("wd_rst_halted", 32'(halted), 32'd0);
        check("wd_rst_reason", 32'(halt_reason), 32'd0);
        check("wd_rst_cycle", cycle_cnt, 32'd0);

        // Saturation on the 3-bit instance
        do_reset();
        max_retire_s = '0;
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'(i * 4));
        check("sat_retire", 32'(retire_cnt_s), 32'd7);
        check("sat_cycle", 32'(cycle_cnt_s), 32'd7);
        check("sat_no_halt", 32'(halted_s), 32'd0);
        max_retire_s = 3'd7;
        cyc(1'b1, 32'h40);
        check("sat_lim_halt", 32'(halted_s), 32'd1);
        check("sat_lim_reason", 32'(halt_reason_s), 32'd2);

        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i * 4));
        check("max_lim_not_yet", 32'(halted_s), 32'd0);
        check("max_lim_retire6", 32'(retire_cnt_s), 32'd6);
        cyc(1'b1, 32'h18);
        check("max_lim_halt", 32'(halted_s), 32'd1);
        check("max_lim_retire7", 32'(retire_cnt_s), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
